uart_rx_fifo_param: RTL and testbench
=====================================

Name: uart_rx_fifo_param

Overview:
- Parametrised successor UART receiver for the `my_uart_top` family. It receives on a serial line with 16x oversampling.
- Baud rate, bit order and parity sense are selected at run time. Data width and FIFO depth are set by parameters.
- Received words are buffered in a first-word-fall-through FIFO and flagged for framing, parity and overrun errors.
- Sits between the pad-side `rs232_rx` line and any byte consumer, e.g. the loopback/echo logic or a CPU register bank.

Parameters:
- DATA_W, 8, data bits per frame; legal range 5..9.
- FIFO_DEPTH, 16, receive FIFO entries; power of two, at least 2.
- DIV_W, 16, width of the run-time baud divisor.

Ports:
- clk  in  1  system clock (50 MHz nominal).
- rst  in  1  synchronous, active-high reset.
- baud_div  in  DIV_W  clk cycles per oversample tick; bit period = 16*baud_div; 0 treated as 1.
- msb_first  in  1  1: first data bit received is the MSB; 0: LSB first.
- parity_odd  in  1  1: odd parity; 0: even parity. Used only with UART_RX_PARITY_EN.
- rs232_rx  in  1  asynchronous serial input; idle high.
- rd_en  in  1  pop request.
- rd_data  out  DATA_W  head of FIFO; valid while rd_valid is high.
- rd_valid  out  1  FIFO not empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current number of entries.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- parity_err  out  1  one-cycle pulse: parity mismatch.
- overrun  out  1  one-cycle pulse: completed word dropped because FIFO full.
- busy  out  1  high while a frame is in progress (state is not IDLE).

Behaviour:
- Reset values: synchroniser flops 1; all outputs 0; rd_data 0; FIFO empty; FSM IDLE.
- Reset mid-frame: the frame is aborted, nothing is pushed and no error is flagged.
- Input sync: 2-FF synchroniser; all sampling uses the synchronised bit rx_s.
- Tick generator: counter runs 0..baud_div-1 and emits a tick on the terminal count. It restarts at 0 on start-edge detection. baud_div is latched at start detection and must not affect the frame in progress.
- Oversample counter os_cnt runs 0..15 per bit. Sample point is os_cnt==7 (mid-bit).
- IDLE: when rx_s==0, clear the counters and go to START.
- START: at mid-bit, if rx_s==1 treat it as a glitch and return to IDLE with no flag. Otherwise go to DATA at the next bit boundary.
- DATA: sample DATA_W bits at mid-bit.
  - msb_first=1: shift left, new bit into bit 0.
  - msb_first=0: shift right, new bit into bit DATA_W-1.
  - msb_first is latched at start detection.
  - After DATA_W bits go to PARITY if enabled, else STOP.
- PARITY: at mid-bit compare XOR(data,bit) with parity_odd. On mismatch, set an internal flag.
- STOP: at mid-bit:
  - rx_s==0: pulse frame_err, discard the word, go to BREAK.
  - rx_s==1 with parity flag set: pulse parity_err, discard the word, go to IDLE.
  - otherwise: push the word and go to IDLE immediately (half stop bit), so back-to-back frames are accepted.
- BREAK: wait for rx_s==1, then go to IDLE. A held-low line yields exactly one frame_err.
- Latency: push occurs on the clock after the stop mid-sample; rd_valid rises one clock after the push.
- FIFO rules:
  - Pop when rd_en && rd_valid; rd_data shows the next entry on the following clock.
  - rd_en while empty is ignored.
  - Push when full without rd_en: pulse overrun and drop the word; stored contents are unchanged.
  - Push and pop in the same cycle: both occur, level unchanged, including when full (no overrun).
  - Pointers wrap modulo FIFO_DEPTH; fifo_level is derived from the pointer difference.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: PARITY state present; one parity bit is expected after the data bits; parity_err is driven.
- Undefined: no parity bit is expected; parity_odd is ignored; parity_err is tied 0.

Decomposition:
- Package uart_pkg holds:
  - FSM state enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - OVS=16 and MID_SAMPLE=7.
  - The baud divisor constant for each standard rate at 50 MHz: DIV_9600=326, DIV_19200=163, DIV_38400=81, DIV_57600=54, DIV_115200=27.
- Sub-module uart_rx_sync_fifo: parametrised FWFT FIFO with push, pop, level and full/empty.

Test Plan:
- baud_div=326, msb_first=1, DATA_W=8, send 0x00..0xFE MSB-first at 104167 ns/bit → each word read back equal, no error pulses.
- msb_first=0, send 0xA5 LSB-first → rd_data=0xA5; the same line waveform with msb_first=1 → rd_data=0xA5 bit-reversed (0xA5), then 0x3C sent LSB-first read with msb_first=1 → 0x3C bit-reversed = 0x3C.
- 20 frames back-to-back with no reads, FIFO_DEPTH=16 → fifo_level=16, 4 overrun pulses; reads return the first 16 words in order.
- Stop bit forced low, then line held low 5 bit times → exactly one frame_err pulse, no push; the next valid frame 0x55 is received.
- With UART_RX_PARITY_EN, parity_odd=0, send 0x07 with parity bit 0 → one parity_err pulse, no push; the same frame with parity bit 1 → 0x07 received.
- Assert rst at the 4th data bit → busy=0 and fifo_level=0 next clock; the following frame 0x81 is received correctly; a 0.3-bit low glitch produces no push and no error.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the oversampling UART receiver family:
//   - rx_state_t : receiver FSM states
//   - OVS, MID_SAMPLE, LAST_SAMPLE : oversampling constants (16 ticks per bit,
//     data sampled on the 8th tick, bit boundary on the 16th)
//   - DIV_* : baud divisors for the standard rates with a 50 MHz clock
//     (clk / (16 * rate), rounded)
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    localparam int unsigned OVS         = 16;
    localparam logic [3:0]  MID_SAMPLE  = 4'd7;
    localparam logic [3:0]  LAST_SAMPLE = 4'(OVS - 1);

    localparam int unsigned DIV_9600   = 326;
    localparam int unsigned DIV_19200  = 163;
    localparam int unsigned DIV_38400  = 81;
    localparam int unsigned DIV_57600  = 54;
    localparam int unsigned DIV_115200 = 27;

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// uart_rx_sync_fifo
// Parametrised first-word-fall-through FIFO for received UART words.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push, wr_data : write request and word
//   pop           : read request, ignored while empty
//   rd_data       : head entry (0 while empty)
//   level         : number of stored entries
//   full, empty   : status flags
//   overrun       : one-cycle pulse when a push was dropped because full
module uart_rx_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   pop,
    output logic [DATA_W-1:0]      rd_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
    output logic                   overrun
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE    = (AW + 1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              overrun_q, overrun_d;
    logic              do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level   = wr_ptr_q - rd_ptr_q;
    assign empty   = (level == '0);
    assign full    = (level == FULL_LEVEL);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign overrun = overrun_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        overrun_d = push && !do_push;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: rtl/uart_rx_fifo_param.sv
// uart_rx_fifo_param
// 16x oversampling UART receiver with run-time baud divisor, bit order and
// parity sense, feeding a first-word-fall-through receive FIFO.
// Optional feature macro: UART_RX_PARITY_EN (one parity bit after the data
// bits; when undefined parity_odd is ignored and parity_err stays 0).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   baud_div     : clk cycles per oversample tick (0 behaves as 1)
//   msb_first    : 1 = first data bit on the line is the MSB
//   parity_odd   : 1 = odd parity, 0 = even parity
//   rs232_rx     : asynchronous serial input, idle high
//   rd_en        : pop request
//   rd_data      : FIFO head, valid while rd_valid
//   rd_valid     : FIFO not empty
//   fifo_level   : number of stored words
//   frame_err    : pulse, stop bit sampled low
//   parity_err   : pulse, parity mismatch
//   overrun      : pulse, completed word dropped on a full FIFO
//   busy         : frame in progress
module uart_rx_fifo_param
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DIV_W-1:0]            baud_div,
    input  logic                        msb_first,
    input  logic                        parity_odd,
    input  logic                        rs232_rx,
    input  logic                        rd_en,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        rd_valid,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        overrun,
    output logic                        busy
);

    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [3:0]       DATA_BITS = 4'(DATA_W);

    rx_state_t         state_q, state_d;
    logic              rx_meta_q, rx_meta_d;
    logic              rx_s_q, rx_s_d;
    logic [DIV_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [3:0]        os_cnt_q, os_cnt_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              msb_q, msb_d;
    logic              par_flag_q, par_flag_d;
    logic              push_q, push_d;
    logic [DATA_W-1:0] push_data_q, push_data_d;
    logic              frame_err_q, frame_err_d;
    logic              parity_err_q, parity_err_d;
    logic              tick, mid_sample, bit_end;
    logic              fifo_empty;
    logic              fifo_full_unused;

`ifndef UART_RX_PARITY_EN
    logic parity_odd_unused;
    assign parity_odd_unused = parity_odd;
`endif

    assign tick       = (tick_cnt_q == (div_q - DIV_ONE));
    assign mid_sample = tick && (os_cnt_q == MID_SAMPLE);
    assign bit_end    = tick && (os_cnt_q == LAST_SAMPLE);

    // Receiver FSM next state. Timing is anchored to the start-edge detection:
    // both counters restart there, so every sample lands half a bit into its bit.
    always_comb begin
        state_d      = state_q;
        rx_meta_d    = rs232_rx;
        rx_s_d       = rx_meta_q;
        tick_cnt_d   = tick_cnt_q;
        div_d        = div_q;
        os_cnt_d     = os_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        msb_d        = msb_q;
        par_flag_d   = par_flag_q;
        push_d       = 1'b0;
        push_data_d  = push_data_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;

        if (state_q != IDLE) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + DIV_ONE;
            if (tick) begin
                os_cnt_d = os_cnt_q + 4'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    tick_cnt_d = '0;
                    os_cnt_d   = '0;
                    bit_cnt_d  = '0;
                    shift_d    = '0;
                    par_flag_d = 1'b0;
                    div_d      = (baud_div == '0) ? DIV_ONE : baud_div;
                    msb_d      = msb_first;
                    state_d    = START;
                end
            end
            START: begin
                if (mid_sample && rx_s_q) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (mid_sample) begin
                    if (msb_q) begin
                        shift_d = {shift_q[DATA_W-2:0], rx_s_q};
                    end else begin
                        shift_d = {rx_s_q, shift_q[DATA_W-1:1]};
                    end
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                if (bit_end && (bit_cnt_q == DATA_BITS)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                // Even parity: XOR of data and parity bit must be 0; odd: 1.
                if (mid_sample && ((^shift_q ^ rx_s_q) != parity_odd)) begin
                    par_flag_d = 1'b1;
                end
                if (bit_end) begin
                    state_d = STOP;
                end
`else
                state_d = IDLE;
`endif
            end
            STOP: begin
                // Leaving at mid stop bit lets a following start bit be caught
                // even if the transmitter's clock runs slightly fast.
                if (mid_sample) begin
                    if (!rx_s_q) begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end else if (par_flag_q) begin
                        parity_err_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        push_d      = 1'b1;
                        push_data_d = shift_q;
                        state_d     = IDLE;
                    end
                end
            end
            BREAK: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            tick_cnt_q   <= '0;
            div_q        <= DIV_ONE;
            os_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            msb_q        <= 1'b0;
            par_flag_q   <= 1'b0;
            push_q       <= 1'b0;
            push_data_q  <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            tick_cnt_q   <= tick_cnt_d;
            div_q        <= div_d;
            os_cnt_q     <= os_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            msb_q        <= msb_d;
            par_flag_q   <= par_flag_d;
            push_q       <= push_d;
            push_data_q  <= push_data_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    uart_rx_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_q),
        .wr_data (push_data_q),
        .pop     (rd_en),
        .rd_data (rd_data),
        .level   (fifo_level),
        .full    (fifo_full_unused),
        .empty   (fifo_empty),
        .overrun (overrun)
    );

    assign rd_valid   = !fifo_empty;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// tb_uart_rx_fifo_param
// Directed testbench for uart_rx_fifo_param: drives serial frames on rs232_rx,
// pops the FIFO and compares against hand-computed words and error counts.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx_fifo_param;
    import uart_pkg::*;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int DIV_W      = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DIV_W-1:0]  baud_div = 16'd1;
    logic              msb_first = 1'b1;
    logic              parity_odd = 1'b0;
    logic              rs232_rx = 1'b1;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [4:0]        fifo_level;
    logic              frame_err;
    logic              parity_err;
    logic              overrun;
    logic              busy;

    int assertCount = 0;
    int failCount   = 0;
    int frameErrTotal  = 0;
    int parityErrTotal = 0;
    int overrunTotal   = 0;

    uart_rx_fifo_param #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_W      (DIV_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_div   (baud_div),
        .msb_first  (msb_first),
        .parity_odd (parity_odd),
        .rs232_rx   (rs232_rx),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .fifo_level (fifo_level),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    // Error pulses last one clock, so each is seen on exactly one falling edge.
    always @(negedge clk) begin
        if (frame_err)  frameErrTotal++;
        if (parity_err) parityErrTotal++;
        if (overrun)    overrunTotal++;
    end

    initial begin
        #1900000;
        $display("[TB] FAIL watchdog: got time limit reached, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic int bitClocks();
        return int'(OVS) * ((baud_div == '0) ? 1 : int'(baud_div));
    endfunction

    task automatic holdLine(input logic level, input int clocks);
        rs232_rx = level;
        repeat (clocks) @(negedge clk);
    endtask

    // One complete frame: start, 8 data bits in the given line order,
    // optional parity bit (correct unless badParity), stop bit.
    task automatic applyStimulus(input logic [7:0] data, input logic lineMsbFirst,
                                 input logic badParity, input logic stopBit);
        int bc;
        bc = bitClocks();
        holdLine(1'b0, bc);
        for (int i = 0; i < 8; i++) begin
            holdLine(lineMsbFirst ? data[7 - i] : data[i], bc);
        end
`ifdef UART_RX_PARITY_EN
        holdLine((^data) ^ parity_odd ^ badParity, bc);
`else
        if (badParity) begin
            $display("[TB] note: parity bit not sent in this build");
        end
`endif
        holdLine(stopBit, bc);
        rs232_rx = 1'b1;
    endtask

    task automatic expectWord(input string tag, input logic [7:0] expected);
        int waitCnt;
        logic gotIt;
        logic [7:0] word;
        waitCnt = 0;
        gotIt = 1'b0;
        word = 8'h00;
        while (!rd_valid && waitCnt < 64) begin
            @(negedge clk);
            waitCnt++;
        end
        if (rd_valid) begin
            gotIt = 1'b1;
            word = rd_data;
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
        end
        checkOutput({tag, " valid"}, 32'(gotIt), 32'd1);
        checkOutput(tag, 32'(word), 32'(expected));
    endtask

    initial begin
        int feBase, peBase, orBase;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("reset fifo_level", 32'(fifo_level), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset frame_err", 32'(frame_err), 32'd0);
        checkOutput("post-reset parity_err", 32'(parity_err), 32'd0);
        checkOutput("post-reset overrun", 32'(overrun), 32'd0);

        // Pop on an empty FIFO is ignored
        rd_en = 1'b1;
        repeat (2) @(negedge clk);
        rd_en = 1'b0;
        checkOutput("empty pop level", 32'(fifo_level), 32'd0);
        checkOutput("empty pop rd_valid", 32'(rd_valid), 32'd0);

        // Sweep 0x00..0xFE MSB-first at the fastest divisor
        feBase = frameErrTotal; peBase = parityErrTotal; orBase = overrunTotal;
        baud_div = 16'd1;
        msb_first = 1'b1;
        for (int v = 0; v < 255; v++) begin
            applyStimulus(8'(v), 1'b1, 1'b0, 1'b1);
            expectWord($sformatf("sweep 0x%02h", v), 8'(v));
        end
        checkOutput("sweep frame_err count", 32'(frameErrTotal - feBase), 32'd0);
        checkOutput("sweep parity_err count", 32'(parityErrTotal - peBase), 32'd0);
        checkOutput("sweep overrun count", 32'(overrunTotal - orBase), 32'd0);

        // Divisor 0 behaves as 1
        baud_div = 16'd0;
        applyStimulus(8'h3A, 1'b1, 1'b0, 1'b1);
        expectWord("div0 word", 8'h3A);

        // Bit order
        baud_div = 16'd2;
        msb_first = 1'b0;
        applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1);
        expectWord("lsb-first A5", 8'hA5);
        msb_first = 1'b1;
        applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1);
        expectWord("reversed A5", 8'hA5);
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b1);
        expectWord("reversed 3C", 8'h3C);
        applyStimulus(8'h01, 1'b0, 1'b0, 1'b1);
        expectWord("reversed 01", 8'h80);
        msb_first = 1'b0;
        applyStimulus(8'h01, 1'b1, 1'b0, 1'b1);
        expectWord("msb line read lsb-first", 8'h80);
        msb_first = 1'b1;

        // Fill past capacity without reading
        orBase = overrunTotal;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(8'(8'h10 + i), 1'b1, 1'b0, 1'b1);
        end
        repeat (4) @(negedge clk);
        checkOutput("full fifo_level", 32'(fifo_level), 32'd16);
        checkOutput("full overrun count", 32'(overrunTotal - orBase), 32'd4);
        for (int i = 0; i < 16; i++) begin
            expectWord($sformatf("drain %0d", i), 8'(8'h10 + i));
        end
        checkOutput("drained level", 32'(fifo_level), 32'd0);

        // Stop bit low followed by a held-low line
        feBase = frameErrTotal;
        applyStimulus(8'hC3, 1'b1, 1'b0, 1'b0);
        holdLine(1'b0, 5 * bitClocks());
        holdLine(1'b1, 2 * bitClocks());
        checkOutput("break frame_err count", 32'(frameErrTotal - feBase), 32'd1);
        checkOutput("break fifo_level", 32'(fifo_level), 32'd0);
        checkOutput("break busy", 32'(busy), 32'd0);
        applyStimulus(8'h55, 1'b1, 1'b0, 1'b1);
        expectWord("after break 55", 8'h55);
        checkOutput("after break frame_err count", 32'(frameErrTotal - feBase), 32'd1);

        // Parity
        peBase = parityErrTotal;
`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
        applyStimulus(8'h07, 1'b1, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("bad parity count", 32'(parityErrTotal - peBase), 32'd1);
        checkOutput("bad parity level", 32'(fifo_level), 32'd0);
        applyStimulus(8'h07, 1'b1, 1'b0, 1'b1);
        expectWord("good even parity 07", 8'h07);
        parity_odd = 1'b1;
        applyStimulus(8'h07, 1'b1, 1'b0, 1'b1);
        expectWord("good odd parity 07", 8'h07);
        checkOutput("parity count after good", 32'(parityErrTotal - peBase), 32'd1);
        parity_odd = 1'b0;
`else
        parity_odd = 1'b1;
        applyStimulus(8'h07, 1'b1, 1'b0, 1'b1);
        expectWord("parity ignored 07", 8'h07);
        checkOutput("parity_err never pulses", 32'(parityErrTotal - peBase), 32'd0);
        parity_odd = 1'b0;
`endif

        // Reset during the 4th data bit of 0x81
        feBase = frameErrTotal;
        holdLine(1'b0, 32);
        holdLine(1'b1, 32);
        holdLine(1'b0, 32);
        holdLine(1'b0, 32);
        holdLine(1'b0, 16);
        checkOutput("busy mid-frame", 32'(busy), 32'd1);
        rs232_rx = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset abort busy", 32'(busy), 32'd0);
        checkOutput("reset abort level", 32'(fifo_level), 32'd0);
        holdLine(1'b1, 3 * 32);
        checkOutput("reset abort frame_err", 32'(frameErrTotal - feBase), 32'd0);
        checkOutput("reset abort no push", 32'(rd_valid), 32'd0);
        applyStimulus(8'h81, 1'b1, 1'b0, 1'b1);
        expectWord("after reset 81", 8'h81);

        // Short low glitch is rejected
        feBase = frameErrTotal; peBase = parityErrTotal;
        holdLine(1'b0, 10);
        holdLine(1'b1, 3 * 32);
        checkOutput("glitch level", 32'(fifo_level), 32'd0);
        checkOutput("glitch busy", 32'(busy), 32'd0);
        checkOutput("glitch frame_err", 32'(frameErrTotal - feBase), 32'd0);
        checkOutput("glitch parity_err", 32'(parityErrTotal - peBase), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
